// File: rtl/snake_dir_queue.sv
`default_nettype none
// ============================================================================
// Module      : snake_dir_queue
// Description : Multi-player snake steering controller. Each key passes through
//               a 2-flop synchroniser and a debouncer. Debounced presses are
//               filtered against the newest queued heading, pushed into a
//               per-player turn queue, and popped one per game tick into the
//               registered direction output.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_dir_queue #(
    parameter int          NUM_PLAYERS     = 2,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [1:0]  INIT_DIR        = 2'b11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4*NUM_PLAYERS-1:0]   key_n,
    input  logic                       tick,
    output logic [2*NUM_PLAYERS-1:0]   direction,
    output logic [NUM_PLAYERS-1:0]     pending,
    output logic [NUM_PLAYERS-1:0]     drop
);

    localparam int c_NUM_KEYS = 4 * NUM_PLAYERS;
    localparam int c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int c_OCC_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_OCC_W-1:0] c_FULL    = c_OCC_W'(QUEUE_DEPTH);

    logic [c_NUM_KEYS-1:0] r_sync1;
    logic [c_NUM_KEYS-1:0] r_sync2;
    logic [c_NUM_KEYS-1:0] w_press;

    // Two-flop synchroniser for every raw key; idle level is released (1)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar k = 0; k < c_NUM_KEYS; k++) begin : g_key
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_stable;
        logic               w_differ;
        logic               w_flip;

        assign w_differ   = (r_sync2[k] != r_stable);
        assign w_flip     = w_differ && (r_cnt == c_DB_LAST);
        // A press is the stable level falling; it is reported on the same
        // edge the stable value toggles so the push lands at that edge too.
        assign w_press[k] = w_flip && r_stable;

        // Count consecutive differing samples; toggle the stable level on the last one
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt    <= '0;
                r_stable <= 1'b1;
            end else if (!w_differ) begin
                r_cnt    <= '0;
            end else if (w_flip) begin
                r_cnt    <= '0;
                r_stable <= ~r_stable;
            end else begin
                r_cnt    <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [1:0]         r_mem [QUEUE_DEPTH];
        logic [c_PTR_W-1:0] r_head;
        logic [c_PTR_W-1:0] r_tail;
        logic [c_OCC_W-1:0] r_count;
        logic [1:0]         r_dir;
        logic               r_pend;
        logic               r_drop;

        logic [3:0]         w_keys;
        logic [1:0]         w_ref;
        logic [1:0]         w_cand;
        logic               w_cand_vld;
        logic               w_empty;
        logic               w_full;
        logic               w_pop;
        logic               w_push;
        logic [c_OCC_W-1:0] w_count_nxt;

        assign w_keys  = w_press[4*p +: 4];
        assign w_empty = (r_count == '0);
        assign w_full  = (r_count == c_FULL);
        // The newest queued turn is what the snake will be heading when this
        // press takes effect, so validity is judged against it.
        assign w_ref   = w_empty ? r_dir : r_mem[r_tail - c_PTR_W'(1)];
        assign w_pop   = tick && !w_empty;
        assign w_push  = w_cand_vld && (!w_full || w_pop);

        // Pick the highest-priority press that is neither a repeat nor a reversal;
        // key bit index equals its direction code
        always_comb begin
            w_cand_vld = 1'b0;
            w_cand     = 2'b00;
            for (int k = 3; k >= 0; k--) begin
                if (w_keys[k] && (2'(k) != w_ref) && ((2'(k) ^ w_ref) != 2'b11)) begin
                    w_cand_vld = 1'b1;
                    w_cand     = 2'(k);
                end
            end
        end

        // Next occupancy from the push/pop combination
        always_comb begin
            w_count_nxt = r_count;
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + c_OCC_W'(1);
                2'b01:   w_count_nxt = r_count - c_OCC_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end

        // Queue storage, pointers, heading and registered status outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_dir   <= INIT_DIR;
                r_pend  <= 1'b0;
                r_drop  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem[r_tail] <= w_cand;
                    r_tail        <= r_tail + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_dir  <= r_mem[r_head];
                    r_head <= r_head + c_PTR_W'(1);
                end
                r_count <= w_count_nxt;
                r_pend  <= (w_count_nxt != '0);
                r_drop  <= w_cand_vld && w_full && !w_pop;
            end
        end

        assign direction[2*p +: 2] = r_dir;
        assign pending[p]          = r_pend;
        assign drop[p]             = r_drop;
    end

endmodule
`default_nettype wire

// File: doc/snake_dir_queue.md
# snake_dir_queue

Multi-player snake steering controller with per-key debounce, press-edge detection and a per-player turn queue. Key presses between game steps are buffered and applied one per `tick`, so fast two-key manoeuvres (e.g. right then down within one step) are not lost. Sits between the board pushbuttons or PS/2 decode and the snake movement engine. One instance serves all players.

## Interface
- `NUM_PLAYERS`, 2: number of independent steering channels (1..4).
- `QUEUE_DEPTH`, 4: turn-queue entries per player (power of two, 2..16).
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples required before a key change is accepted (≥1).
- `INIT_DIR`, 2'b11: direction loaded at reset (down).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `key_n`  in  4*NUM_PLAYERS  raw keys, active-low; player p uses bits [4p+3:4p]: bit0 up, bit1 left, bit2 right, bit3 down.
- `tick`  in  1  one-cycle game-step strobe; pops one queued turn per player.
- `direction`  out  2*NUM_PLAYERS  current heading of player p at [2p+1:2p]; 00 up, 01 left, 10 right, 11 down.
- `pending`  out  NUM_PLAYERS  bit p high while player p's queue is non-empty.
- `drop`  out  NUM_PLAYERS  one-cycle pulse: a valid press of player p was discarded because the queue was full.

## Operation
- Per key: 2-flop synchroniser, then debouncer. A debounce counter counts cycles where the synchronised value differs from the stable value; it clears on any matching sample. The stable value toggles on the edge where the DEBOUNCE_CYCLES-th consecutive differing sample is seen. Stable resets to 1 (released).
- Press event: the stable value toggles 1→0. Releases and held keys generate nothing; there is no auto-repeat.
- Reference direction per player = newest queue entry, or `direction` if the queue is empty.
- Candidate selection: among keys pressing this cycle, take the highest priority (up > left > right > down) that is neither equal to the reference nor its opposite. Opposite means `cand ^ ref == 2'b11`. If none qualifies, nothing is pushed and `drop` stays low.
- Push: a candidate is written at the tail. If the queue is full and there is no pop this cycle, the candidate is discarded and `drop[p]` pulses for one cycle.
- Pop: on `tick`, each non-empty queue moves its head into `direction`. An empty queue leaves `direction` unchanged.
- Same-cycle pop and push: both occur. A full queue accepts the push. The reference is still the pre-pop newest entry, or `direction` if the queue was empty.
- Players are fully independent. Queue pointers wrap modulo QUEUE_DEPTH. The occupancy counter is $clog2(QUEUE_DEPTH)+1 bits wide.

## Timing
- Reset (synchronous) values: `direction` = INIT_DIR for all players; queues empty; `pending` = 0; `drop` = 0; synchronisers and stable values = 1; counters = 0. A `tick` or press in the `rst` cycle is ignored. Reset mid-operation flushes queued turns at the next edge.
- Press latency: if `key_n` bit is low before edge E0 and held, the stable value falls and the entry is written at edge E0+1+DEBOUNCE_CYCLES. `pending` rises at that same edge.
- Pop latency: a `tick` sampled at edge T updates `direction` at T. `pending` falls at T if that was the last entry.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- All outputs are registered.

## Test plan
- Reset then idle, NUM_PLAYERS=2 → `direction`=4'b1111, `pending`=0, `drop`=0. Tick with no keys → direction unchanged.
- P0 (dir down), press right; tick; press up; tick → direction 10 then 00; `pending` 1→0 after each tick. P1 is unaffected.
- P0 dir down, press up → no push (reversal). Press down → no push (duplicate). Press left and up in the same cycle → left queued (up is rejected as reversal).
- QUEUE_DEPTH=4: alternate left/down presses without tick → 4 accepted. The 5th valid press pulses `drop[0]` for exactly 1 cycle. Repeat the 5th press coincident with `tick` → accepted, no drop, `direction` takes the head.
- Key bounce of 3 cycles low with DEBOUNCE_CYCLES=16 → no entry. Clean press → entry at edge E0+17.
- Queue holds 3 entries, assert `rst` → next edge: `direction`=INIT_DIR, `pending`=0. A tick in the same cycle is ignored.
